// File: rtl/adda_dac_tx.sv
// Streaming transmitter for the 8-bit DAC on the ULX3S AD/DA board.
// Samples go through a FIFO and out on the DA bus with a divided DACLK.
module adda_dac_tx #(
  parameter int                DATA_W        = 8,
  parameter int                CLK_DIV       = 4,
  parameter int                FIFO_DEPTH    = 16,
  parameter int                PRIME_LEVEL   = 4,
  parameter logic [DATA_W-1:0] IDLE_CODE     = 8'h80,
  parameter bit                UNDERRUN_HOLD = 1'b0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [DATA_W-1:0]               o_da_data,
  output logic                            o_da_clk,
  output logic                            o_underrun,
  output logic [15:0]                     o_underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     o_fill
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     fill;
  logic [DATA_W-1:0] da_data, da_data_nxt;
  logic              da_clk;
  logic              underrun, underrun_nxt;
  logic [15:0]       underrun_cnt;
  logic              push, pop, period_end;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign s_ready    = !i_rst && (fill != FW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign period_end = (state != IDLE) && (cnt == CW'(CLK_DIV - 1));

  // next-state: every decision and pop is taken at the period end only
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    pop          = 1'b0;
    underrun_nxt = 1'b0;
    da_data_nxt  = da_data;
    case (state)
      IDLE: begin
        da_data_nxt = IDLE_CODE;
        if (i_enable) state_nxt = PRIME;
      end
      PRIME, RUN: begin
        cnt_nxt = period_end ? '0 : cnt + 1'b1;
        if (period_end) begin
          if (!i_enable) begin
            state_nxt   = IDLE;
            da_data_nxt = IDLE_CODE;
          end else if (state == PRIME) begin
            if (fill >= FW'(PRIME_LEVEL)) begin
              state_nxt   = RUN;
              pop         = 1'b1;
              da_data_nxt = mem[rd_ptr];
            end
          end else if (fill != '0) begin
            pop         = 1'b1;
            da_data_nxt = mem[rd_ptr];
          end else begin
            underrun_nxt = 1'b1;
            state_nxt    = PRIME;
            if (!UNDERRUN_HOLD) da_data_nxt = IDLE_CODE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control and output registers; reset also flushes the FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      da_data      <= IDLE_CODE;
      da_clk       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      da_data  <= da_data_nxt;
      da_clk   <= (cnt_nxt >= CW'(CLK_DIV / 2));
      underrun <= underrun_nxt;
      if (underrun_nxt) underrun_cnt <= sat_inc(underrun_cnt);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // sample storage carries no reset
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  assign o_da_data      = da_data;
  assign o_da_clk       = da_clk;
  assign o_underrun     = underrun;
  assign o_underrun_cnt = underrun_cnt;
  assign o_fill         = fill;

endmodule

// File: doc/adda_dac_tx.md
Name: adda_dac_tx

Overview:
Streaming transmitter for the 8-bit DAC on the ULX3S AD/DA add-on board. Accepts samples over a valid/ready handshake into a small FIFO. Generates the DAC sample clock (DACLK) by dividing i_clk, and drives the DA data bus with a fixed setup time before each DACLK rising edge. It is the output-side companion to the ADC capture path. Its pins map to the DA_PORT GPIOs and the DACLK pin in the top level.

Parameters:
DATA_W, 8, sample width; matches the DA bus.
CLK_DIV, 4, i_clk cycles per DAC sample; even, >= 2.
FIFO_DEPTH, 16, sample FIFO entries; power of 2, >= 4.
PRIME_LEVEL, 4, FIFO fill required before playback starts or restarts; 1..FIFO_DEPTH.
IDLE_CODE, 8'h80, mid-scale code driven when idle or priming.
UNDERRUN_HOLD, 0, 1 = repeat last sample on underrun; 0 = drive IDLE_CODE.

Ports:
i_clk  in  1  system clock (25 MHz board clock)
i_rst  in  1  synchronous, active-high reset
i_enable  in  1  playback enable
s_data  in  DATA_W  input sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept a sample
o_da_data  out  DATA_W  DA bus (DADB7..0)
o_da_clk  out  1  DACLK; the DAC latches on the rising edge
o_underrun  out  1  one-cycle pulse per underrun event
o_underrun_cnt  out  16  saturating underrun counter
o_fill  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_da_data=IDLE_CODE, o_da_clk=0, o_underrun=0, o_underrun_cnt=0, o_fill=0.
  - State=IDLE, divider cnt=0.
  - s_ready=0 while i_rst=1.
- Reset mid-operation flushes the FIFO and immediately restores all reset values.
- Push: a sample is written when s_valid && s_ready.
  - s_ready = !i_rst && (fill != FIFO_DEPTH). It is combinational from registered fill.
  - Push is accepted in any state, including IDLE, so the FIFO can be preloaded.
- Divider: cnt runs 0..CLK_DIV-1 in PRIME and RUN. It is held at 0 in IDLE.
  - o_da_clk is registered: 1 when cnt >= CLK_DIV/2, else 0.
  - o_da_data changes only on the cycle cnt becomes 0. This gives CLK_DIV/2 cycles of setup before the rising edge and CLK_DIV/2 cycles of hold after it.
- "Period end" means the cycle with cnt==CLK_DIV-1. All state decisions and pops happen there.
- States:
  - IDLE: o_da_clk=0, o_da_data=IDLE_CODE. Goes to PRIME on the next cycle when i_enable=1, with cnt starting at 0.
  - PRIME: clock runs and o_da_data is driven per the underrun rule (IDLE_CODE or held value). At period end:
    - i_enable=0 -> IDLE.
    - else if fill >= PRIME_LEVEL -> RUN and pop one sample; that sample appears on o_da_data the next cycle (cnt=0).
  - RUN: at period end:
    - i_enable=0 -> IDLE; no pop; o_da_data becomes IDLE_CODE.
    - else if fill > 0 -> pop; the next sample is shown.
    - else (underrun) -> o_underrun=1 for one cycle; o_underrun_cnt +1, saturating at 16'hFFFF; o_da_data becomes IDLE_CODE or the last sample (per UNDERRUN_HOLD); go to PRIME.
- i_enable deassertion mid-period always completes the current DAC period. FIFO contents are retained in IDLE.
- Simultaneous push and pop: fill is unchanged.
  - A push at fill==FIFO_DEPTH is impossible because s_ready=0.
  - A pop at full raises s_ready on the following cycle.
- Pop-side decisions use the registered fill of the current cycle. A push in the same cycle counts for the next period.
- Latency from the first accepted sample to the DA bus: the first period end with fill>=PRIME_LEVEL in PRIME, plus 1 cycle.

Test Plan:
1. Reset: assert i_rst for 3 cycles mid-RUN with fill=7 -> o_fill=0, o_da_data=8'h80, o_da_clk=0, s_ready=0 during reset, s_ready=1 the cycle after release.
2. Priming and playback:
   - Stimulus: i_enable=1, then push 0x10,0x11,0x12,0x13 back-to-back.
   - Required: o_da_data stays 0x80 until the first period end with fill=4.
   - Required: then 0x10,0x11,0x12,0x13, each held 4 cycles, with o_da_clk rising 2 cycles after each change.
3. Underrun:
   - Continue test 2 with no further pushes -> after 0x13, o_da_data=0x80, o_underrun pulses once, o_underrun_cnt=1, state PRIME with the clock still toggling.
   - Repeat with UNDERRUN_HOLD=1 -> o_da_data holds 0x13.
4. Full FIFO: i_enable=0, push 17 samples 0x00..0x10 -> s_ready=0 after the 16th, 0x10 not accepted, o_fill=16. Then enable -> playback outputs 0x00..0x0F in order.
5. Disable mid-period: in RUN, drop i_enable at cnt=1 -> the current sample is held through cnt=3, then o_da_data=0x80 and o_da_clk=0, with remaining fill unchanged.
6. Simultaneous push/pop: with fill=5 in RUN, assert s_valid continuously on the period-end cycle -> o_fill stays 5 across that cycle. Output order is preserved with no duplicated or dropped sample.
